// File: rtl/drum_pkg.sv
// Shared constants and types for the drum packet SPI transmitter.
//
// Packet layout (byte 0 is shifted out first, MSB first):
//   bytes S1_OFF..S1_OFF+14 : sensor 1 record
//   bytes S2_OFF..S2_OFF+14 : sensor 2 record
//   byte  KICK_OFF          : {7'b0, kick_pending}
//   byte  CAL_OFF           : {7'b0, cal_pending}
package drum_pkg;

    localparam int PKT_BYTES    = 32;
    localparam int SENSOR_BYTES = 15;

    localparam int S1_OFF   = 0;
    localparam int S2_OFF   = 15;
    localparam int KICK_OFF = 30;
    localparam int CAL_OFF  = 31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        ACK   = 2'd2
    } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input, followed by a
// single-cycle rise/fall pulse generator in the clk domain.
//
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset (clears the whole chain)
//   async_in : asynchronous input
//   sync_out : synchronized level
//   rise     : one-cycle pulse on a synchronized 0->1 transition
//   fall     : one-cycle pulse on a synchronized 1->0 transition
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_out = sync_q;
    assign rise     = sync_q & ~prev_q;
    assign fall     = ~sync_q & prev_q;

endmodule

// File: rtl/drum_packet_spi_tx.sv
// Snapshots two sensor records plus button flags into a packet register and
// shifts it out to an MCU that clocks the data with its own SPI clock
// (mode 0: data changes after the falling edge, MCU samples on rising edge).
//
// Ports:
//   clk, rst      : system clock, synchronous active-high reset
//   s1_data       : sensor 1 record (15 bytes, byte 0 in the top bits)
//   s2_data       : sensor 2 record, same layout
//   sample_valid  : one-cycle pulse, sensor records valid
//   kick_press    : debounced kick button level
//   cal_press     : debounced calibrate button level
//   mcu_sck       : asynchronous MCU SPI clock
//   mcu_load      : asynchronous MCU acknowledge
//   mcu_sdo       : serial data to the MCU
//   mcu_done      : packet ready to be read
//   overrun_cnt   : saturating count of samples dropped while busy
module drum_packet_spi_tx
#(
    parameter int PKT_BYTES    = 32,
    parameter int SENSOR_BYTES = 15
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [8*SENSOR_BYTES-1:0] s1_data,
    input  logic [8*SENSOR_BYTES-1:0] s2_data,
    input  logic                      sample_valid,
    input  logic                      kick_press,
    input  logic                      cal_press,
    input  logic                      mcu_sck,
    input  logic                      mcu_load,
    output logic                      mcu_sdo,
    output logic                      mcu_done,
    output logic [7:0]                overrun_cnt
);
    import drum_pkg::*;

    localparam int PKT_BITS = PKT_BYTES * 8;
    localparam int CNT_W    = $clog2(PKT_BITS + 1);
    localparam int IDX_W    = $clog2(PKT_BITS);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(PKT_BITS);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PKT_BITS - 1);

    // MCU-side signal synchronization
    logic sck_level, sck_rise, sck_fall;
    logic load_level, load_rise, load_fall;

    sync_edge_det u_sck_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (mcu_sck),
        .sync_out (sck_level),
        .rise     (sck_rise),
        .fall     (sck_fall)
    );

    sync_edge_det u_load_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (mcu_load),
        .sync_out (load_level),
        .rise     (load_rise),
        .fall     (load_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sck_level, sck_rise, load_fall};

    // State
    state_t               state_q, state_d;
    logic [PKT_BITS-1:0]  snap_q, snap_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 sdo_q, sdo_d;
    logic                 done_q, done_d;
    logic [7:0]           ovr_q, ovr_d;
    logic                 kick_q, kick_d;
    logic                 cal_q, cal_d;

    // A press seen in the snapshot cycle itself still counts for this packet.
    logic kick_bit, cal_bit;
    assign kick_bit = kick_q | kick_press;
    assign cal_bit  = cal_q  | cal_press;

    // Candidate packet, byte 0 at the top so bit 0 of the stream is the MSB.
    logic [PKT_BITS-1:0] new_pkt;

    for (genvar gi = 0; gi < PKT_BYTES; gi++) begin : g_byte
        if (gi >= S1_OFF && gi < S1_OFF + SENSOR_BYTES) begin : g_s1
            assign new_pkt[PKT_BITS-1-8*gi -: 8] =
                s1_data[8*(SENSOR_BYTES-(gi-S1_OFF))-1 -: 8];
        end else if (gi >= S2_OFF && gi < S2_OFF + SENSOR_BYTES) begin : g_s2
            assign new_pkt[PKT_BITS-1-8*gi -: 8] =
                s2_data[8*(SENSOR_BYTES-(gi-S2_OFF))-1 -: 8];
        end else if (gi == KICK_OFF) begin : g_kick
            assign new_pkt[PKT_BITS-1-8*gi -: 8] = {7'b0, kick_bit};
        end else if (gi == CAL_OFF) begin : g_cal
            assign new_pkt[PKT_BITS-1-8*gi -: 8] = {7'b0, cal_bit};
        end else begin : g_pad
            assign new_pkt[PKT_BITS-1-8*gi -: 8] = 8'h00;
        end
    end

    logic [CNT_W-1:0] next_cnt;
    logic [IDX_W-1:0] tx_idx;
    logic             snapshot;

    always_comb begin
        state_d  = state_q;
        snap_d   = snap_q;
        cnt_d    = cnt_q;
        sdo_d    = sdo_q;
        ovr_d    = ovr_q;
        kick_d   = kick_q | kick_press;
        cal_d    = cal_q  | cal_press;
        snapshot = 1'b0;
        next_cnt = cnt_q + 1'b1;
        tx_idx   = IDX_TOP - next_cnt[IDX_W-1:0];

        case (state_q)
            IDLE: begin
                sdo_d = 1'b0;
                if (sample_valid) begin
                    snapshot = 1'b1;
                    snap_d   = new_pkt;
                    cnt_d    = '0;
                    sdo_d    = new_pkt[PKT_BITS-1];
                    state_d  = READY;
                end
            end
            READY: begin
                // An acknowledge ends the transfer wherever the MCU is.
                if (load_rise) begin
                    sdo_d   = 1'b0;
                    state_d = ACK;
                end else if (sck_fall && cnt_q < CNT_END) begin
                    cnt_d = next_cnt;
                    sdo_d = (next_cnt < CNT_END) ? snap_q[tx_idx] : 1'b0;
                end
            end
            ACK: begin
                sdo_d = 1'b0;
                if (!load_level) begin
                    state_d = IDLE;
                end
            end
            default: begin
                sdo_d   = 1'b0;
                state_d = IDLE;
            end
        endcase

        // Samples arriving while a packet is pending (including the
        // ACK->IDLE cycle) are dropped and counted.
        if (sample_valid && state_q != IDLE && ovr_q != 8'hFF) begin
            ovr_d = ovr_q + 8'd1;
        end

        if (snapshot) begin
            kick_d = kick_press;
            cal_d  = cal_press;
        end

        done_d = (state_d == READY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            snap_q  <= '0;
            cnt_q   <= '0;
            sdo_q   <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 8'd0;
            kick_q  <= 1'b0;
            cal_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
            sdo_q   <= sdo_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            kick_q  <= kick_d;
            cal_q   <= cal_d;
        end
    end

    assign mcu_sdo     = sdo_q;
    assign mcu_done    = done_q;
    assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_drum_packet_spi_tx.sv
module tb_drum_packet_spi_tx;

    logic         clk = 1'b0;
    logic         rst;
    logic [119:0] s1_data, s2_data;
    logic         sample_valid, kick_press, cal_press;
    logic         mcu_sck, mcu_load;
    logic         mcu_sdo, mcu_done;
    logic [7:0]   overrun_cnt;

    drum_packet_spi_tx #(.PKT_BYTES(32), .SENSOR_BYTES(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .s1_data      (s1_data),
        .s2_data      (s2_data),
        .sample_valid (sample_valid),
        .kick_press   (kick_press),
        .cal_press    (cal_press),
        .mcu_sck      (mcu_sck),
        .mcu_load     (mcu_load),
        .mcu_sdo      (mcu_sdo),
        .mcu_done     (mcu_done),
        .overrun_cnt  (overrun_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_ovr = 0;

    typedef struct {
        logic [119:0] s1;
        logic [119:0] s2;
        int           kick_cycles;
        logic         cal_at_snap;
        logic [7:0]   b30;
        logic [7:0]   b31;
    } vec_t;

    vec_t vecs[6];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One MCU SCK period of 6 clk cycles; sdo sampled just before the rise.
    task automatic read_bits(input int n, output logic [255:0] got);
        got = '0;
        for (int i = 0; i < n; i++) begin
            got = {got[254:0], mcu_sdo};
            mcu_sck = 1'b1;
            tick(3);
            mcu_sck = 1'b0;
            tick(3);
        end
    endtask

    task automatic snap_pulse(input logic [119:0] a, input logic [119:0] b, input logic cal);
        s1_data = a;
        s2_data = b;
        cal_press = cal;
        sample_valid = 1'b1;
        check("done_before_snap", 256'(mcu_done), 256'(1'b0));
        tick(1);
        sample_valid = 1'b0;
        cal_press = 1'b0;
        check("done_after_snap", 256'(mcu_done), 256'(1'b1));
        check("sdo_first_bit", 256'(mcu_sdo), 256'(a[119]));
    endtask

    task automatic ack();
        int k;
        mcu_load = 1'b1;
        for (k = 0; k < 8; k++) begin
            tick(1);
            if (!mcu_done) break;
        end
        check("done_drop_within_4", 256'(k < 4), 256'(1'b1));
        mcu_load = 1'b0;
        tick(6);
    endtask

    task automatic read_check_packet(input string name, input logic [255:0] exp);
        logic [255:0] got;
        read_bits(256, got);
        for (int i = 0; i < 32; i++)
            check($sformatf("%s_byte%0d", name, i), 256'(got[255-8*i -: 8]), 256'(exp[255-8*i -: 8]));
        check({name, "_sdo_after_256"}, 256'(mcu_sdo), 256'(1'b0));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [255:0] exp_pkt;
        logic [255:0] got;
        logic [119:0] sa, sb;

        vecs[0] = '{120'h0102030405060708090A0B0C0D0E0F, 120'h1112131415161718191A1B1C1D1E1F, 0,   1'b0, 8'h00, 8'h00};
        vecs[1] = '{120'hA5A55A5AFF00123456789ABCDEF080, 120'h00112233445566778899AABBCCDDEE, 200, 1'b0, 8'h01, 8'h00};
        vecs[2] = '{120'h8899AABBCCDDEEFF00112233445566, 120'hFEDCBA98765432100123456789ABCD, 0,   1'b0, 8'h00, 8'h00};
        vecs[3] = '{120'hC3C3C3C3C3C3C3C3C3C3C3C3C3C3C3, 120'h3C3C3C3C3C3C3C3C3C3C3C3C3C3C3C, 0,   1'b1, 8'h00, 8'h01};
        vecs[4] = '{120'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, 120'h000000000000000000000000000001, 0,   1'b0, 8'h00, 8'h01};
        vecs[5] = '{120'h80000000000000000000000000007F, 120'h7E7E7E7E7E7E7E7E7E7E7E7E7E7E7E, 0,   1'b0, 8'h00, 8'h00};

        rst = 1'b1; s1_data = '0; s2_data = '0; sample_valid = 1'b0;
        kick_press = 1'b0; cal_press = 1'b0; mcu_sck = 1'b0; mcu_load = 1'b0;
        tick(4);
        rst = 1'b0;
        tick(2);
        check("reset_done", 256'(mcu_done), 256'(1'b0));
        check("reset_sdo", 256'(mcu_sdo), 256'(1'b0));
        check("reset_overrun", 256'(overrun_cnt), 256'(8'd0));

        // Table-driven packets.
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].kick_cycles > 0) begin
                kick_press = 1'b1;
                tick(vecs[v].kick_cycles);
                kick_press = 1'b0;
                tick(5);
            end
            snap_pulse(vecs[v].s1, vecs[v].s2, vecs[v].cal_at_snap);
            exp_pkt = {vecs[v].s1, vecs[v].s2, vecs[v].b30, vecs[v].b31};
            read_check_packet($sformatf("vec%0d", v), exp_pkt);
            read_bits(1, got);
            check($sformatf("vec%0d_sdo_extra_edge", v), 256'(mcu_sdo), 256'(1'b0));
            check($sformatf("vec%0d_done_held", v), 256'(mcu_done), 256'(1'b1));
            ack();
            check($sformatf("vec%0d_done_after_ack", v), 256'(mcu_done), 256'(1'b0));
        end

        // Acknowledge after 40 bits, with a sample landing on the ACK->IDLE cycle.
        sa = 120'h5566778899AABBCCDDEEFF00112233;
        sb = 120'h445566778899AABBCCDDEEFF001122;
        snap_pulse(sa, sb, 1'b0);
        exp_pkt = {sa, sb, 8'h00, 8'h00};
        read_bits(40, got);
        check("load40_first_bits", got, {216'b0, exp_pkt[255:216]});
        mcu_load = 1'b1;
        begin
            int k;
            for (k = 0; k < 8; k++) begin
                tick(1);
                if (!mcu_done) break;
            end
            check("load40_done_drop", 256'(k < 4), 256'(1'b1));
        end
        mcu_load = 1'b0;
        tick(2);
        sample_valid = 1'b1;
        tick(1);
        sample_valid = 1'b0;
        exp_ovr++;
        tick(3);
        check("ack_exit_drop_done", 256'(mcu_done), 256'(1'b0));
        check("ack_exit_drop_count", 256'(overrun_cnt), 256'(exp_ovr));
        sa = 120'hF0E1D2C3B4A5968778695A4B3C2D1E;
        snap_pulse(sa, sb, 1'b0);
        read_check_packet("after_load40", {sa, sb, 8'h00, 8'h00});
        ack();

        // Reset in the middle of a transfer.
        sa = 120'h123456789ABCDEF0123456789ABCDE;
        snap_pulse(sa, sb, 1'b0);
        read_bits(100, got);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_ovr = 0;
        check("midrst_done", 256'(mcu_done), 256'(1'b0));
        check("midrst_sdo", 256'(mcu_sdo), 256'(1'b0));
        check("midrst_overrun", 256'(overrun_cnt), 256'(exp_ovr));
        tick(3);
        sa = 120'h89ABCDEF0123456789ABCDEF012345;
        snap_pulse(sa, sb, 1'b0);
        read_check_packet("after_rst", {sa, sb, 8'h00, 8'h00});
        ack();

        // Overrun while READY: snapshot must survive, counter saturates.
        sa = 120'hAAAAAAAA55555555AAAAAAAA555555;
        snap_pulse(sa, sb, 1'b0);
        for (int i = 0; i < 3; i++) begin
            s1_data = ~sa;
            s2_data = ~sb;
            sample_valid = 1'b1;
            tick(1);
            sample_valid = 1'b0;
            tick(1);
            exp_ovr++;
        end
        check("overrun_3", 256'(overrun_cnt), 256'(exp_ovr));
        read_check_packet("overrun_pkt", {sa, sb, 8'h00, 8'h00});
        for (int i = 0; i < 300; i++) begin
            sample_valid = 1'b1;
            tick(1);
            sample_valid = 1'b0;
            tick(1);
        end
        check("overrun_sat", 256'(overrun_cnt), 256'(8'd255));
        ack();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
